sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared 16-bit asynchronous SRAM of the SLC-3 system. It sits between the memory side of the CPU/Mem2IO path and a second requester (program loader/DMA), and owns the SRAM pins: address `A`, the `Mem_bus` data bus, and the active-low `CE`/`OE`/`WE`/`UB`/`LB` strobes. It grants one requester at a time, round-robin on conflict, and drives a fixed setup/access/hold sequence with a configurable number of wait states.

---
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and setup/access/hold sequencer for the shared
// asynchronous SRAM. Every pin except the data bus comes straight from a flop.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [1:0]  dma_be,
  input  logic [19:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [19:0] A,
  inout  wire  [15:0] Mem_bus,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        UB,
  output logic        LB,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  wait_q;
  logic        last_grant_q;  // 1 = dma; also names the owner of the running transaction
  logic        we_q;
  logic        drive_q;
  logic [15:0] wdata_q;

  logic        pick_dma;
  logic        sel_we;
  logic [1:0]  sel_be;
  logic [19:0] sel_addr;
  logic [15:0] sel_wdata;

  // On conflict the port that did not own the previous transaction wins.
  always_comb begin
    pick_dma  = dma_req && (!cpu_req || !last_grant_q);
    sel_we    = pick_dma ? dma_we    : cpu_we;
    sel_be    = pick_dma ? dma_be    : cpu_be;
    sel_addr  = pick_dma ? dma_addr  : cpu_addr;
    sel_wdata = pick_dma ? dma_wdata : cpu_wdata;
  end

  assign Mem_bus = drive_q ? wdata_q : 16'hzzzz;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      drive_q      <= 1'b0;
      wdata_q      <= '0;
      A            <= '0;
      CE           <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      UB           <= 1'b1;
      LB           <= 1'b1;
      busy         <= 1'b0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_req || dma_req) begin
            state_q      <= StSetup;
            last_grant_q <= pick_dma;
            we_q         <= sel_we;
            wdata_q      <= sel_wdata;
            A            <= sel_addr;
            busy         <= 1'b1;
            CE           <= 1'b0;
            WE           <= 1'b1;
            if (sel_we) begin
              OE      <= 1'b1;
              UB      <= ~sel_be[1];
              LB      <= ~sel_be[0];
              drive_q <= 1'b1;
            end else begin
              OE      <= 1'b0;
              UB      <= 1'b0;
              LB      <= 1'b0;
              drive_q <= 1'b0;
            end
          end
        end
        StSetup: begin
          state_q <= StAccess;
          wait_q  <= WaitLoad;
          if (we_q) begin
            WE <= 1'b0;
          end
        end
        StAccess: begin
          if (wait_q == 4'd0) begin
            state_q <= StDone;
            WE      <= 1'b1;
            OE      <= 1'b1;
            UB      <= 1'b1;
            LB      <= 1'b1;
            if (last_grant_q) begin
              dma_ack <= 1'b1;
              if (!we_q) begin
                dma_rdata <= Mem_bus;
              end
            end else begin
              cpu_ack <= 1'b1;
              if (!we_q) begin
                cpu_rdata <= Mem_bus;
              end
            end
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StDone: begin
          // CE and the write data were held through this cycle for hold time.
          state_q <= StIdle;
          CE      <= 1'b1;
          drive_q <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: instance 0 runs WAIT_CYCLES=2, instance 1
// runs WAIT_CYCLES=1, each with its own small behavioural SRAM.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [1:0]  cpu_be    [2];
  logic [19:0] cpu_addr  [2];
  logic [15:0] cpu_wdata [2];
  logic        cpu_ack   [2];
  logic [15:0] cpu_rdata [2];
  logic        dma_req   [2];
  logic        dma_we    [2];
  logic [1:0]  dma_be    [2];
  logic [19:0] dma_addr  [2];
  logic [15:0] dma_wdata [2];
  logic        dma_ack   [2];
  logic [15:0] dma_rdata [2];
  logic [19:0] a         [2];
  logic        ce        [2];
  logic        oe        [2];
  logic        we_n      [2];
  logic        ub        [2];
  logic        lb        [2];
  logic        busy      [2];
  wire  [15:0] bus0;
  wire  [15:0] bus1;

  logic [15:0] mem [2][2048];

  int n_vec  = 0;
  int n_miss = 0;

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut2 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_be(cpu_be[0]), .cpu_addr(cpu_addr[0]),
    .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_be(dma_be[0]), .dma_addr(dma_addr[0]),
    .dma_wdata(dma_wdata[0]), .dma_ack(dma_ack[0]), .dma_rdata(dma_rdata[0]),
    .A(a[0]), .Mem_bus(bus0), .CE(ce[0]), .OE(oe[0]), .WE(we_n[0]), .UB(ub[0]), .LB(lb[0]),
    .busy(busy[0])
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_be(cpu_be[1]), .cpu_addr(cpu_addr[1]),
    .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_be(dma_be[1]), .dma_addr(dma_addr[1]),
    .dma_wdata(dma_wdata[1]), .dma_ack(dma_ack[1]), .dma_rdata(dma_rdata[1]),
    .A(a[1]), .Mem_bus(bus1), .CE(ce[1]), .OE(oe[1]), .WE(we_n[1]), .UB(ub[1]), .LB(lb[1]),
    .busy(busy[1])
  );

  // SRAM models: drive on read, write selected bytes on any edge seen with WE low.
  assign bus0 = (!ce[0] && !oe[0] && we_n[0]) ? mem[0][a[0][10:0]] : 16'hzzzz;
  assign bus1 = (!ce[1] && !oe[1] && we_n[1]) ? mem[1][a[1][10:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce[0] && !we_n[0]) begin
      if (!lb[0]) mem[0][a[0][10:0]][7:0]  = bus0[7:0];
      if (!ub[0]) mem[0][a[0][10:0]][15:8] = bus0[15:8];
    end
    if (!ce[1] && !we_n[1]) begin
      if (!lb[1]) mem[1][a[1][10:0]][7:0]  = bus1[7:0];
      if (!ub[1]) mem[1][a[1][10:0]][15:8] = bus1[15:8];
    end
  end

  function automatic logic [15:0] bus_of(input int d);
    return (d == 0) ? bus0 : bus1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction; bit k of each mask is the pin state k cycles after the request cycle.
  task automatic run_txn(input int d, input bit use_dma, input bit wr, input logic [1:0] be,
                         input logic [19:0] addr, input logic [15:0] wdata,
                         output int ack_k, output logic [15:0] rdata,
                         output logic [15:0] m_ce, output logic [15:0] m_oe,
                         output logic [15:0] m_we, output logic [15:0] m_ub,
                         output logic [15:0] m_lb, output logic [15:0] m_drv,
                         output logic [15:0] m_busy);
    ack_k = 0; rdata = '0;
    m_ce = '0; m_oe = '0; m_we = '0; m_ub = '0; m_lb = '0; m_drv = '0; m_busy = '0;
    @(negedge clk);
    if (use_dma) begin
      dma_req[d] = 1'b1; dma_we[d] = wr; dma_be[d] = be; dma_addr[d] = addr; dma_wdata[d] = wdata;
    end else begin
      cpu_req[d] = 1'b1; cpu_we[d] = wr; cpu_be[d] = be; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
    end
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      m_ce[k]   = !ce[d];
      m_oe[k]   = !oe[d];
      m_we[k]   = !we_n[d];
      m_ub[k]   = !ub[d];
      m_lb[k]   = !lb[d];
      m_busy[k] = busy[d];
      m_drv[k]  = (bus_of(d) === wdata);
      if (use_dma ? dma_ack[d] : cpu_ack[d]) begin
        ack_k = k;
        rdata = use_dma ? dma_rdata[d] : cpu_rdata[d];
        cpu_req[d] = 1'b0;
        dma_req[d] = 1'b0;
      end
      if (ack_k != 0 && k == ack_k + 1) break;
    end
    cpu_req[d] = 1'b0;
    dma_req[d] = 1'b0;
  endtask

  int          ack_k;
  logic [15:0] rd, m_ce, m_oe, m_we, m_ub, m_lb, m_drv, m_busy;
  int          who  [4];
  int          when [4];
  int          n_ack, cnt_cpu, cnt_dma, acks_seen;
  bit          raise_cpu, raise_dma;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_be[d] = 2'b00; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      dma_req[d] = 1'b0; dma_we[d] = 1'b0; dma_be[d] = 2'b00; dma_addr[d] = '0; dma_wdata[d] = '0;
      for (int i = 0; i < 2048; i++) mem[d][i] = 16'h0000;
    end
    mem[0][11'h012] = 16'hBEEF;
    mem[0][11'h400] = 16'hABCD;
    mem[0][11'h020] = 16'h1111;
    mem[0][11'h030] = 16'h2222;
    mem[1][11'h007] = 16'h0F0F;
    mem[1][11'h008] = 16'h2468;

    apply_reset();
    check_eq("rst_strobes", 32'({ce[0], oe[0], we_n[0], ub[0], lb[0]}), 32'h1F);
    check_eq("rst_addr", 32'(a[0]), 32'h0);
    check_eq("rst_busy", 32'(busy[0]), 32'h0);
    check_eq("rst_acks", 32'({cpu_ack[0], dma_ack[0]}), 32'h0);
    check_eq("rst_rdata", {cpu_rdata[0], dma_rdata[0]}, 32'h0);
    check_eq("rst_strobes_w1", 32'({ce[1], oe[1], we_n[1], ub[1], lb[1]}), 32'h1F);

    // cpu read, WAIT_CYCLES=2
    run_txn(0, 1'b0, 1'b0, 2'b00, 20'h00012, 16'hDEAD, ack_k, rd, m_ce, m_oe, m_we, m_ub, m_lb,
            m_drv, m_busy);
    check_eq("rd_ack_cycle", 32'(ack_k), 32'd4);
    check_eq("rd_ce_low", 32'(m_ce), 32'h001E);
    check_eq("rd_oe_low", 32'(m_oe), 32'h000E);
    check_eq("rd_we_low", 32'(m_we), 32'h0000);
    check_eq("rd_busy", 32'(m_busy), 32'h001E);
    check_eq("rd_cpu_rdata", 32'(rd), 32'hBEEF);
    check_eq("rd_dma_rdata", 32'(dma_rdata[0]), 32'h0);

    // dma write, low byte only
    run_txn(0, 1'b1, 1'b1, 2'b01, 20'h00400, 16'h1234, ack_k, rd, m_ce, m_oe, m_we, m_ub, m_lb,
            m_drv, m_busy);
    check_eq("wr_ack_cycle", 32'(ack_k), 32'd4);
    check_eq("wr_we_low", 32'(m_we), 32'h000C);
    check_eq("wr_ub_low", 32'(m_ub), 32'h0000);
    check_eq("wr_lb_low", 32'(m_lb), 32'h000E);
    check_eq("wr_oe_low", 32'(m_oe), 32'h0000);
    check_eq("wr_ce_low", 32'(m_ce), 32'h001E);
    check_eq("wr_bus_drive", 32'(m_drv), 32'h001E);
    check_eq("wr_mem", 32'(mem[0][11'h400]), 32'hAB34);
    check_eq("wr_cpu_rdata_kept", 32'(cpu_rdata[0]), 32'hBEEF);

    // simultaneous requests, each re-raised in the IDLE cycle after its ack
    apply_reset();
    for (int i = 0; i < 4; i++) begin who[i] = -1; when[i] = -1; end
    n_ack = 0; cnt_cpu = 0; cnt_dma = 0; raise_cpu = 1'b0; raise_dma = 1'b0;
    @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 20'h00020;
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 20'h00030;
    for (int c = 1; c <= 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (raise_cpu) begin cpu_req[0] = 1'b1; raise_cpu = 1'b0; end
      if (raise_dma) begin dma_req[0] = 1'b1; raise_dma = 1'b0; end
      if (cpu_ack[0] && n_ack < 4) begin
        who[n_ack] = 0; when[n_ack] = c; n_ack++; cnt_cpu++;
        cpu_req[0] = 1'b0; raise_cpu = (cnt_cpu < 2);
      end
      if (dma_ack[0] && n_ack < 4) begin
        who[n_ack] = 1; when[n_ack] = c; n_ack++; cnt_dma++;
        dma_req[0] = 1'b0; raise_dma = (cnt_dma < 2);
      end
    end
    cpu_req[0] = 1'b0;
    dma_req[0] = 1'b0;
    check_eq("arb_n_ack", 32'(n_ack), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("arb_who%0d", i), 32'(who[i]), 32'(i % 2));
      check_eq($sformatf("arb_when%0d", i), 32'(when[i]), 32'(4 + 5 * i));
    end
    check_eq("arb_cpu_rdata", 32'(cpu_rdata[0]), 32'h1111);
    check_eq("arb_dma_rdata", 32'(dma_rdata[0]), 32'h2222);

    // reset in the first ACCESS cycle of a cpu write
    @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_be[0] = 2'b11;
    cpu_addr[0] = 20'h00050; cpu_wdata[0] = 16'h5555;
    repeat (2) @(negedge clk);
    check_eq("rst_mid_pre_we", 32'(we_n[0]), 32'h0);
    rst_n = 1'b0;
    cpu_req[0] = 1'b0;
    cpu_we[0] = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_strobes", 32'({ce[0], oe[0], we_n[0], ub[0], lb[0]}), 32'h1F);
    check_eq("rst_mid_busy", 32'(busy[0]), 32'h0);
    check_eq("rst_mid_bus_released", 32'(bus0 === 16'h5555), 32'h0);
    acks_seen = int'(cpu_ack[0]);
    @(negedge clk);
    rst_n = 1'b1;
    acks_seen += int'(cpu_ack[0]);
    repeat (6) begin
      @(negedge clk);
      acks_seen += int'(cpu_ack[0]);
    end
    check_eq("rst_mid_no_ack", 32'(acks_seen), 32'h0);
    check_eq("rst_mid_rdata_cleared", 32'(cpu_rdata[0]), 32'h0);
    run_txn(0, 1'b0, 1'b0, 2'b00, 20'h00012, 16'hDEAD, ack_k, rd, m_ce, m_oe, m_we, m_ub, m_lb,
            m_drv, m_busy);
    check_eq("rst_mid_rd_ack", 32'(ack_k), 32'd4);
    check_eq("rst_mid_rd_data", 32'(rd), 32'hBEEF);

    // WAIT_CYCLES=1 instance
    run_txn(1, 1'b0, 1'b0, 2'b00, 20'h00007, 16'hDEAD, ack_k, rd, m_ce, m_oe, m_we, m_ub, m_lb,
            m_drv, m_busy);
    check_eq("w1_rd_ack", 32'(ack_k), 32'd3);
    check_eq("w1_rd_oe_low", 32'(m_oe), 32'h0006);
    check_eq("w1_rd_data", 32'(rd), 32'h0F0F);
    run_txn(1, 1'b0, 1'b1, 2'b00, 20'h00008, 16'hFFFF, ack_k, rd, m_ce, m_oe, m_we, m_ub, m_lb,
            m_drv, m_busy);
    check_eq("w1_wr_ack", 32'(ack_k), 32'd3);
    check_eq("w1_wr_ub_low", 32'(m_ub), 32'h0000);
    check_eq("w1_wr_lb_low", 32'(m_lb), 32'h0000);
    check_eq("w1_wr_we_low", 32'(m_we), 32'h0004);
    check_eq("w1_wr_bus_drive", 32'(m_drv), 32'h000E);
    check_eq("w1_wr_mem", 32'(mem[1][11'h008]), 32'h2468);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
